// File: rtl/logic_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_eval_pkg
// Description : Shared types, golden truth tables and the per-lane function
//               evaluator for the logic_eval_pipe block.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_eval_pkg;

  // Function selector; encoding matches the in_mode/bist_mode port values.
  typedef enum logic [1:0] {
    MODE_NAND_OR = 2'd0,
    MODE_INV     = 2'd1,
    MODE_MAJ     = 2'd2,
    MODE_XOR3    = 2'd3
  } mode_e;

  // Self-test sequencer states.
  typedef enum logic [2:0] {
    BIST_IDLE  = 3'd0,
    BIST_DRAIN = 3'd1,
    BIST_RUN   = 3'd2,
    BIST_WAIT  = 3'd3,
    BIST_DONE  = 3'd4
  } bist_state_e;

  // Expected lane output for each mode, bit index is {A,B,C}.
  localparam logic [7:0] GOLDEN [4] = '{8'hF1, 8'h0E, 8'hE8, 8'h96};

  // One lane of the selectable 3-operand function.
  function automatic logic eval_fn(input mode_e mode, input logic a,
                                   input logic b, input logic c);
    logic x;
    x = 1'b0;
    case (mode)
      MODE_NAND_OR: x = a | ~(b | c);
      MODE_INV:     x = ~(a | ~(b | c));
      MODE_MAJ:     x = (a & b) | (a & c) | (b & c);
      MODE_XOR3:    x = a ^ b ^ c;
      default:      x = 1'b0;
    endcase
    return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_eval_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_eval_pipe_if
// Description : Operand/result stream handshakes and BIST control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_eval_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_x;
  logic             bist_start;
  logic [1:0]       bist_mode;
  logic             bist_busy;
  logic             bist_done;
  logic             bist_pass;

  // Stimulus source / result sink side.
  modport master (
    output in_valid, in_mode, in_a, in_b, in_c, out_ready, bist_start, bist_mode,
    input  in_ready, out_valid, out_x, bist_busy, bist_done, bist_pass
  );

  // Evaluator side.
  modport slave (
    input  in_valid, in_mode, in_a, in_b, in_c, out_ready, bist_start, bist_mode,
    output in_ready, out_valid, out_x, bist_busy, bist_done, bist_pass
  );
endinterface
`default_nettype wire

// File: rtl/logic_eval_bist.sv
`default_nettype none
// ============================================================================
// Module      : logic_eval_bist
// Description : Self-test sequencer: drains the pipe, issues the 8 operand
//               combinations, checks returning results against GOLDEN.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_eval_bist
  import logic_eval_pkg::*;
#(
  parameter int         WIDTH      = 8,
  parameter logic [1:0] RESET_MODE = 2'd0
) (
  input  wire              clk,
  input  wire              rst_n,
  input  wire              bist_start,
  input  wire [1:0]        bist_mode_in,
  input  wire              pipe_empty,
  input  wire              chk_valid,
  input  wire [2:0]        chk_tag,
  input  wire [WIDTH-1:0]  chk_x,
  output logic             idle,
  output logic             issue,
  output logic [2:0]       idx,
  output mode_e            mode,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  bist_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        wait_q, wait_d;
  mode_e       mode_q, mode_d;
  logic        error_q, error_d;
  logic        pass_q, pass_d;

  logic [WIDTH-1:0] w_expected;
  logic             w_mismatch;

  // Every lane of a BIST result must equal the golden bit for its tag.
  assign w_expected = {WIDTH{GOLDEN[mode_q][chk_tag]}};
  assign w_mismatch = chk_valid & (chk_x != w_expected);

  // Sequencer state and checker flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BIST_IDLE;
      idx_q   <= 3'd0;
      wait_q  <= 1'b0;
      mode_q  <= mode_e'(RESET_MODE);
      error_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      mode_q  <= mode_d;
      error_q <= error_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state, issue control and error accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    mode_d  = mode_q;
    error_d = error_q | w_mismatch;
    pass_d  = pass_q;
    issue   = 1'b0;
    case (state_q)
      BIST_IDLE: begin
        if (bist_start) begin
          state_d = BIST_DRAIN;
          mode_d  = mode_e'(bist_mode_in);
          error_d = 1'b0;
          pass_d  = 1'b0;
        end
      end
      BIST_DRAIN: begin
        if (pipe_empty) begin
          state_d = BIST_RUN;
          idx_d   = 3'd0;
        end
      end
      BIST_RUN: begin
        issue = 1'b1;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = BIST_WAIT;
          wait_d  = 1'b0;
        end
      end
      BIST_WAIT: begin
        wait_d = 1'b1;
        // Second cycle: the final beat is being checked right now, so fold
        // its outcome into the verdict published alongside done.
        if (wait_q) begin
          state_d = BIST_DONE;
          pass_d  = ~error_d;
        end
      end
      BIST_DONE: begin
        state_d = BIST_IDLE;
      end
      default: begin
        state_d = BIST_IDLE;
      end
    endcase
  end

  assign idle = (state_q == BIST_IDLE);
  assign busy = (state_q == BIST_DRAIN) | (state_q == BIST_RUN) | (state_q == BIST_WAIT);
  assign done = (state_q == BIST_DONE);
  assign pass = pass_q;
  assign idx  = idx_q;
  assign mode = mode_q;

endmodule
`default_nettype wire

// File: rtl/logic_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_eval_pipe
// Description : Two-stage valid/ready pipeline evaluating a selectable
//               3-operand bitwise function over WIDTH lanes, with BIST.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_eval_pipe
  import logic_eval_pkg::*;
#(
  parameter int         WIDTH      = 8,
  parameter logic [1:0] RESET_MODE = 2'd0
) (
  input  wire              clk,
  input  wire              rst_n,
  logic_eval_pipe_if.slave bus
);

  // Stage 1: operands, function and tag.
  logic             s1_valid_q, s1_valid_d;
  logic             s1_bist_q, s1_bist_d;
  mode_e            s1_mode_q, s1_mode_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_c_q, s1_c_d;
  logic [2:0]       s1_tag_q, s1_tag_d;
  // Stage 2: result and tag.
  logic             s2_valid_q, s2_valid_d;
  logic             s2_bist_q, s2_bist_d;
  logic [WIDTH-1:0] s2_x_q, s2_x_d;
  logic [2:0]       s2_tag_q, s2_tag_d;
  // Rolling tag for normal beats.
  logic [2:0]       tag_cnt_q, tag_cnt_d;

  logic             w_stall;
  logic             w_accept;
  logic             w_pipe_empty;
  logic             w_chk_valid;
  logic             w_bist_idle;
  logic             w_bist_issue;
  logic [2:0]       w_bist_idx;
  mode_e            w_bist_mode;
  logic [WIDTH-1:0] w_x;

  // Only a visible result can back-pressure; BIST beats ignore out_ready.
  assign w_stall       = s2_valid_q & ~s2_bist_q & ~bus.out_ready;
  assign bus.in_ready  = rst_n & ~w_stall & w_bist_idle;
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = s2_valid_q & ~s2_bist_q;
  assign bus.out_x     = s2_x_q;
  assign w_pipe_empty  = ~s1_valid_q & ~s2_valid_q;
  assign w_chk_valid   = s2_valid_q & s2_bist_q;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign w_x[gi] = eval_fn(s1_mode_q, s1_a_q[gi], s1_b_q[gi], s1_c_q[gi]);
    end
  endgenerate

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_bist_q  <= 1'b0;
      s1_mode_q  <= mode_e'(RESET_MODE);
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_tag_q   <= 3'd0;
      s2_valid_q <= 1'b0;
      s2_bist_q  <= 1'b0;
      s2_x_q     <= '0;
      s2_tag_q   <= 3'd0;
      tag_cnt_q  <= 3'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_bist_q  <= s1_bist_d;
      s1_mode_q  <= s1_mode_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_bist_q  <= s2_bist_d;
      s2_x_q     <= s2_x_d;
      s2_tag_q   <= s2_tag_d;
      tag_cnt_q  <= tag_cnt_d;
    end
  end

  // Stage advance: both stages move together unless stalled; bubbles move too.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_bist_d  = s1_bist_q;
    s1_mode_d  = s1_mode_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_bist_d  = s2_bist_q;
    s2_x_d     = s2_x_q;
    s2_tag_d   = s2_tag_q;
    tag_cnt_d  = tag_cnt_q;
    if (!w_stall) begin
      s1_valid_d = w_accept | w_bist_issue;
      s1_bist_d  = w_bist_issue;
      if (w_bist_issue) begin
        s1_a_d    = {WIDTH{w_bist_idx[2]}};
        s1_b_d    = {WIDTH{w_bist_idx[1]}};
        s1_c_d    = {WIDTH{w_bist_idx[0]}};
        s1_mode_d = w_bist_mode;
        s1_tag_d  = w_bist_idx;
      end else if (w_accept) begin
        s1_a_d    = bus.in_a;
        s1_b_d    = bus.in_b;
        s1_c_d    = bus.in_c;
        s1_mode_d = mode_e'(bus.in_mode);
        s1_tag_d  = tag_cnt_q;
        tag_cnt_d = tag_cnt_q + 3'd1;
      end
      s2_valid_d = s1_valid_q;
      s2_bist_d  = s1_bist_q;
      if (s1_valid_q) begin
        s2_x_d   = w_x;
        s2_tag_d = s1_tag_q;
      end
    end
  end

  logic_eval_bist #(
    .WIDTH      (WIDTH),
    .RESET_MODE (RESET_MODE)
  ) u_bist (
    .clk          (clk),
    .rst_n        (rst_n),
    .bist_start   (bus.bist_start),
    .bist_mode_in (bus.bist_mode),
    .pipe_empty   (w_pipe_empty),
    .chk_valid    (w_chk_valid),
    .chk_tag      (s2_tag_q),
    .chk_x        (s2_x_q),
    .idle         (w_bist_idle),
    .issue        (w_bist_issue),
    .idx          (w_bist_idx),
    .mode         (w_bist_mode),
    .busy         (bus.bist_busy),
    .done         (bus.bist_done),
    .pass         (bus.bist_pass)
  );

endmodule
`default_nettype wire

// File: tb/tb_logic_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_eval_pipe
// Description : Directed bench for logic_eval_pipe: function table, latency,
//               back-pressure, BIST runs and asynchronous reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_eval_pipe;

  localparam int WIDTH = 8;
  localparam int NVEC  = 13;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic_eval_pipe_if #(.WIDTH(WIDTH)) bus ();

  logic_eval_pipe #(
    .WIDTH      (WIDTH),
    .RESET_MODE (2'd0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] x;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Samples after each edge until bist_done is seen (bounded).
  task automatic watch_bist(output int busy_n, output int done_n,
                            output logic pass_at_done, output logic ov_seen);
    busy_n       = 0;
    done_n       = 0;
    pass_at_done = 1'b0;
    ov_seen      = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus.bist_busy) busy_n++;
      if (bus.out_valid) ov_seen = 1'b1;
      if (bus.bist_done) begin
        done_n++;
        pass_at_done = bus.bist_pass;
        break;
      end
      step();
    end
  endtask

  task automatic check_bist_run(input string tag);
    int   busy_n;
    int   done_n;
    logic pass_at_done;
    logic ov_seen;
    watch_bist(busy_n, done_n, pass_at_done, ov_seen);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd11);
    chk({tag, "_done_seen"}, 64'(done_n), 64'd1);
    chk({tag, "_pass"}, 64'(pass_at_done), 64'd1);
    chk({tag, "_no_out_valid"}, 64'(ov_seen), 64'd0);
    step();
    chk({tag, "_done_pulse_ends"}, 64'(bus.bist_done), 64'd0);
    chk({tag, "_pass_held"}, 64'(bus.bist_pass), 64'd1);
    chk({tag, "_ready_after"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic drive_beat(input logic [1:0] m, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c);
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_c     = c;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0]  = '{2'd0, 8'h0F, 8'h33, 8'h55, 8'h8F};
    vecs[1]  = '{2'd1, 8'h0F, 8'h33, 8'h55, 8'h70};
    vecs[2]  = '{2'd2, 8'h0F, 8'h33, 8'h55, 8'h17};
    vecs[3]  = '{2'd3, 8'h0F, 8'h33, 8'h55, 8'h69};
    vecs[4]  = '{2'd0, 8'h00, 8'h00, 8'h00, 8'hFF};
    vecs[5]  = '{2'd0, 8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[6]  = '{2'd1, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{2'd1, 8'h00, 8'h0F, 8'hF0, 8'hFF};
    vecs[8]  = '{2'd2, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    vecs[9]  = '{2'd2, 8'hAA, 8'hCC, 8'hF0, 8'hE8};
    vecs[10] = '{2'd3, 8'hAA, 8'hCC, 8'hF0, 8'h96};
    vecs[11] = '{2'd0, 8'hAA, 8'hCC, 8'hF0, 8'hAB};
    vecs[12] = '{2'd1, 8'hAA, 8'hCC, 8'hF0, 8'h54};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_mode    = 2'd0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_c       = '0;
    bus.out_ready  = 1'b1;
    bus.bist_start = 1'b0;
    bus.bist_mode  = 2'd0;

    // Reset state.
    #3;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_x", 64'(bus.out_x), 64'd0);
    chk("rst_busy", 64'(bus.bist_busy), 64'd0);
    chk("rst_done", 64'(bus.bist_done), 64'd0);
    chk("rst_pass", 64'(bus.bist_pass), 64'd0);
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // Function table, single beats, 2-cycle latency.
    for (int i = 0; i < NVEC; i++) begin
      drive_beat(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c);
      chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d_early_valid", i), 64'(bus.out_valid), 64'd0);
      step();
      chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("vec%0d_x", i), 64'(bus.out_x), 64'(vecs[i].x));
      step();
    end

    // Back-to-back beats, mode switch per beat.
    drive_beat(2'd2, 8'h0F, 8'h33, 8'h55);
    step();
    drive_beat(2'd3, 8'h0F, 8'h33, 8'h55);
    step();
    bus.in_valid = 1'b0;
    chk("b2b_first_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b_first_x", 64'(bus.out_x), 64'h17);
    step();
    chk("b2b_second_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b_second_x", 64'(bus.out_x), 64'h69);
    step();
    chk("b2b_drained", 64'(bus.out_valid), 64'd0);

    // Back-pressure with two beats in flight.
    bus.out_ready = 1'b0;
    drive_beat(2'd0, 8'h0F, 8'h33, 8'h55);
    step();
    drive_beat(2'd3, 8'h0F, 8'h33, 8'h55);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall%0d_in_ready", k), 64'(bus.in_ready), 64'd0);
      chk($sformatf("stall%0d_valid", k), 64'(bus.out_valid), 64'd1);
      chk($sformatf("stall%0d_x", k), 64'(bus.out_x), 64'h8F);
      if (k < 3) step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("unstall_second_valid", 64'(bus.out_valid), 64'd1);
    chk("unstall_second_x", 64'(bus.out_x), 64'h69);
    step();
    chk("unstall_drained", 64'(bus.out_valid), 64'd0);

    // BIST on an empty pipe, every mode.
    for (int m = 0; m < 4; m++) begin
      bus.bist_mode  = 2'(m);
      bus.bist_start = 1'b1;
      step();
      bus.bist_start = 1'b0;
      chk($sformatf("bist%0d_in_ready_low", m), 64'(bus.in_ready), 64'd0);
      check_bist_run($sformatf("bist%0d", m));
    end

    // BIST requested together with a beat that then stalls at the output.
    bus.out_ready  = 1'b0;
    bus.bist_mode  = 2'd0;
    bus.bist_start = 1'b1;
    drive_beat(2'd2, 8'h0F, 8'h33, 8'h55);
    step();
    bus.bist_start = 1'b0;
    bus.in_valid   = 1'b0;
    chk("drain_busy", 64'(bus.bist_busy), 64'd1);
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_valid", k), 64'(bus.out_valid), 64'd1);
      chk($sformatf("drain%0d_x", k), 64'(bus.out_x), 64'h17);
      chk($sformatf("drain%0d_in_ready", k), 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check_bist_run("drain_bist");

    // Asynchronous reset in the middle of RUN (idx 4), then a fresh BIST.
    bus.bist_mode  = 2'd2;
    bus.bist_start = 1'b1;
    step();
    bus.bist_start = 1'b0;
    repeat (5) step();
    chk("mid_run_busy", 64'(bus.bist_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.bist_busy), 64'd0);
    chk("abort_done", 64'(bus.bist_done), 64'd0);
    chk("abort_pass", 64'(bus.bist_pass), 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_out_x", 64'(bus.out_x), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    #4 rst_n = 1'b1;
    step();
    chk("rerst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.bist_mode  = 2'd1;
    bus.bist_start = 1'b1;
    step();
    bus.bist_start = 1'b0;
    check_bist_run("rerun_bist");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_eval_pipe.md
Name: logic_eval_pipe

Overview:
- Parametrised, pipelined successor to the team's 3-input dataflow logic circuits.
- Evaluates a selectable 3-operand bitwise function across WIDTH lanes, with valid/ready handshaking and a 2-stage register pipeline.
- Built-in self-test (BIST) FSM sweeps all 8 operand combinations and checks the results against golden truth tables.
- Sits between a stimulus source and a result sink in lab/test harnesses.

Parameters:
- WIDTH, 8, lane count; bit width of A, B, C and X (1..64).
- RESET_MODE, 0, value loaded into the internal mode register on reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_mode  input  2  function select for this beat.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_c  input  WIDTH  operand C.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts the result.
- out_x  output  WIDTH  result.
- bist_start  input  1  one-cycle request to run the self-test.
- bist_mode  input  2  function exercised by the BIST.
- bist_busy  output  1  BIST in progress.
- bist_done  output  1  one-cycle pulse when the BIST finishes.
- bist_pass  output  1  result of the last BIST; held until the next start.

Behaviour:
- Functions, bitwise per lane:
  - mode 0: X = A | ~(B|C), i.e. ~(~A & (B|C)).
  - mode 1: complement of mode 0.
  - mode 2: majority, (A&B)|(A&C)|(B&C).
  - mode 3: A^B^C.
- Reset (async, rst_n=0): clear all stage valids, out_valid=0, out_x=0, in_ready=0. BIST FSM goes to IDLE; bist_busy=0, bist_done=0, bist_pass=0; mode register = RESET_MODE. Reset asserted mid-beat or mid-BIST aborts with no output. First cycle after release: in_ready=1.
- Pipeline:
  - S1 registers operands, mode and a 3-bit tag. S2 registers the computed X and the tag.
  - Latency is 2 cycles from an accepted beat to out_valid when not stalled.
  - stall = out_valid & ~out_ready. Both stages hold while stalled; otherwise both advance, and bubbles advance too (no bubble collapse).
  - in_ready = ~stall & (FSM == IDLE). A beat is accepted when in_valid & in_ready.
  - out_x and out_valid stay stable while stalled. Throughput is 1 beat/cycle with out_ready held high.
- BIST FSM (IDLE, DRAIN, RUN, WAIT, DONE):
  - IDLE: bist_start=1 -> DRAIN and clear the error flag. bist_start in any other state is ignored.
  - DRAIN: in_ready=0; normal results still drain through the handshake. When S1 and S2 are both empty -> RUN.
  - RUN: issue idx 0..7, one per cycle. Operands are A={WIDTH{idx[2]}}, B={WIDTH{idx[1]}}, C={WIDTH{idx[0]}}; mode is bist_mode, sampled on entry to DRAIN; tag=idx. BIST beats never assert out_valid and ignore out_ready. After idx 7 -> WAIT.
  - WAIT: 2 cycles until the last BIST beat clears S2 -> DONE.
  - DONE: bist_done=1 for exactly one cycle; bist_pass = ~error -> IDLE.
  - bist_busy=1 in DRAIN, RUN and WAIT.
- BIST check: each BIST beat leaving S2 must equal {WIDTH{GOLDEN[mode][tag]}}; any mismatch sets error.
- Golden tables, indexed by {A,B,C}: mode0 8'hF1, mode1 8'h0E, mode2 8'hE8, mode3 8'h96.
- Simultaneous events:
  - bist_start in the same cycle as an accepted beat: the beat is accepted, then the FSM drains it.
  - A change of in_mode between beats takes effect per beat, with no bubble inserted.

Decomposition:
- Package logic_eval_pkg:
  - mode enum (MODE_NAND_OR, MODE_INV, MODE_MAJ, MODE_XOR3).
  - BIST state enum.
  - GOLDEN constant array [4][8].
  - function eval_fn(mode, a, b, c), shared by the RTL and the bench.
- Sub-module logic_eval_bist: FSM, idx counter, checker. The top keeps the pipeline and muxes operands.

Test Plan:
- WIDTH=8, mode0, A=8'h0F, B=8'h33, C=8'h55, out_ready=1 -> out_x=8'h8F, out_valid exactly 2 cycles after acceptance.
- Back-to-back beats: mode2 then mode3 with the same operands -> 8'h17 then 8'h69 on consecutive cycles.
- out_ready=0 for 4 cycles with 2 beats in flight -> in_ready=0, out_x held at the first result, no loss or duplication after release.
- bist_start with bist_mode=3 and the pipeline empty -> bist_busy for 11 cycles (DRAIN 1, RUN 8, WAIT 2), then bist_done pulse with bist_pass=1; out_valid stays 0 throughout.
- bist_start while a normal beat is stalled (out_ready=0) -> FSM stays in DRAIN until out_ready=1 delivers the beat, then the BIST runs and passes.
- rst_n low during RUN at idx=4 -> all outputs 0 immediately (async); after release, a fresh BIST passes.
